// File: rtl/wisc_fetch_pkg.sv
// Shared definitions for the WISC front-end fetch sequencer.
package wisc_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam logic [4:0] HALT_OPC_DEFAULT = 5'b00000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_unit_cla16.sv
// 16-bit carry-lookahead adder: 4-bit groups, group generate/propagate chained across groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic carry;
    gg = '0;
    gp = '0;
    gc = '0;
    sum = '0;
    carry = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Bit carries restart from the lookahead carry at each group boundary.
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) carry = gc[i/4];
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Front-end PC/fetch sequencer: one outstanding imem read, decode handshake,
// and branch/jump redirect with wrong-path squash.
module fetch_redirect_unit
  import wisc_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OPC = HALT_OPC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_redirect,
  input  logic               ex_jr,
  input  logic [15:0]        ex_sum1,
  input  logic [15:0]        ex_sum2,
  input  logic               id_ready,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic [15:0]        imem_rdata,
  input  logic               imem_done,
  output logic [INSTR_W-1:0] instr_out,
  output logic [15:0]        pc_plus_2,
  output logic               instr_valid,
  output logic               halted,
  output logic               err
);

  fetch_state_e state;
  logic [15:0]  pc;
  logic [15:0]  addr_q;
  logic [15:0]  addr_plus_2;
  logic [15:0]  target;

  cla16 u_inc (
    .a   (addr_q),
    .b   (16'h0002),
    .cin (1'b0),
    .sum (addr_plus_2)
  );

  assign target      = ex_jr ? ex_sum2 : ex_sum1;
  assign imem_addr   = addr_q;
  assign imem_req    = (state == S_FETCH) || (state == S_DRAIN);
  assign instr_valid = (state == S_VALID);
  assign halted      = (state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      addr_q    <= RESET_PC;
      instr_out <= NOP_INSTR;
      pc_plus_2 <= RESET_PC + 16'd2;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          addr_q <= pc;
          state  <= S_FETCH;
        end
        S_FETCH: begin
          if (ex_redirect) begin
            pc <= target;
            if (target[0]) begin
              err   <= 1'b1;
              state <= S_HALT;
            end else if (imem_done) begin
              addr_q <= target;
            end else begin
              // The outstanding read cannot be cancelled; wait it out in DRAIN.
              state <= S_DRAIN;
            end
          end else if (imem_done) begin
            instr_out <= imem_rdata;
            pc_plus_2 <= addr_plus_2;
            pc        <= addr_plus_2;
            state     <= S_VALID;
          end
        end
        S_DRAIN: begin
          if (ex_redirect) begin
            pc <= target;
            if (target[0]) begin
              err   <= 1'b1;
              state <= S_HALT;
            end else if (imem_done) begin
              addr_q <= target;
              state  <= S_FETCH;
            end
          end else if (imem_done) begin
            addr_q <= pc;
            state  <= S_FETCH;
          end
        end
        S_VALID: begin
          if (ex_redirect) begin
            pc <= target;
            if (target[0]) begin
              err   <= 1'b1;
              state <= S_HALT;
            end else begin
              addr_q <= target;
              state  <= S_FETCH;
            end
          end else if (id_ready) begin
            if (instr_out[15:11] == HALT_OPC) begin
              state <= S_HALT;
            end else begin
              addr_q <= pc;
              state  <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench for fetch_redirect_unit with a program-order reference model
// and a variable-latency memory responder.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_redirect, ex_jr, id_ready;
  logic [15:0] ex_sum1, ex_sum2;
  logic        imem_req, imem_done;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] instr_out, pc_plus_2;
  logic        instr_valid, halted, err;

  fetch_redirect_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ex_redirect (ex_redirect),
    .ex_jr       (ex_jr),
    .ex_sum1     (ex_sum1),
    .ex_sum2     (ex_sum2),
    .id_ready    (id_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_done   (imem_done),
    .instr_out   (instr_out),
    .pc_plus_2   (pc_plus_2),
    .instr_valid (instr_valid),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc = -1;
  int n_acc = 0;

  // memory responder
  logic [15:0] halt_addr;
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr_held;
  int          lat_min, lat_max;

  // stimulus policy
  int          rdy_pct, redir_pct;
  bit          gap_chk;
  bit          force_redir;
  logic        force_jr;
  logic [15:0] force_s1, force_s2;

  // reference model
  logic [15:0] exp_pc;
  bit          exp_err, exp_halt;
  bit          pend_hold, pend_redir;
  logic [15:0] redir_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [4:0] opc;
    if (a == halt_addr) return 16'h0000;
    opc = (a[5:1] == 5'd0) ? 5'd31 : a[5:1];
    return {opc, a[11:1]};
  endfunction

  function automatic logic [15:0] rand_tgt();
    int r;
    logic [6:0] lo;
    r = $urandom_range(15, 0);
    lo = 7'($urandom);
    if (r == 0) return 16'hFFFC;
    if (r == 1) return 16'hFFFE;
    return {8'h00, lo, 1'b0};
  endfunction

  // One clock cycle: called at a falling edge, checks outputs, drives inputs, advances the model.
  task automatic step();
    logic [15:0] tgt;
    logic [15:0] w;
    if (exp_halt) begin
      check("halted", {31'd0, halted}, 32'd1);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_vld", {31'd0, instr_valid}, 32'd0);
    end
    check("err", {31'd0, err}, {31'd0, exp_err});
    if (pend_hold) begin
      check("hold_vld", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", {16'd0, instr_out}, {16'd0, mem_word(exp_pc)});
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    if (pend_redir) begin
      check("redir_req", {31'd0, imem_req}, 32'd1);
      check("redir_addr", {16'd0, imem_addr}, {16'd0, redir_tgt});
    end

    imem_done  = 1'b0;
    imem_rdata = 16'($urandom);
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy      = 1'b1;
        mem_cnt       = $urandom_range(lat_max, lat_min);
        mem_addr_held = imem_addr;
      end else begin
        check("addr_stable", {16'd0, imem_addr}, {16'd0, mem_addr_held});
      end
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_done  = 1'b1;
        imem_rdata = mem_word(mem_addr_held);
        mem_busy   = 1'b0;
      end
    end else begin
      mem_busy = 1'b0;
    end

    ex_redirect = 1'b0;
    ex_jr       = 1'($urandom);
    ex_sum1     = rand_tgt();
    ex_sum2     = rand_tgt();
    if (force_redir) begin
      ex_redirect = 1'b1;
      ex_jr       = force_jr;
      ex_sum1     = force_s1;
      ex_sum2     = force_s2;
      force_redir = 1'b0;
    end else if ((imem_req || instr_valid || halted) && $urandom_range(99, 0) < redir_pct) begin
      ex_redirect = 1'b1;
    end
    id_ready = ($urandom_range(99, 0) < rdy_pct);

    tgt = ex_jr ? ex_sum2 : ex_sum1;
    pend_hold  = 1'b0;
    pend_redir = 1'b0;
    if (!exp_halt) begin
      if (ex_redirect && (imem_req || instr_valid)) begin
        exp_pc = tgt;
        if (tgt[0]) begin
          exp_err  = 1'b1;
          exp_halt = 1'b1;
        end else if (instr_valid) begin
          pend_redir = 1'b1;
          redir_tgt  = tgt;
        end
      end else if (instr_valid && id_ready) begin
        w = mem_word(exp_pc);
        check("acc_instr", {16'd0, instr_out}, {16'd0, w});
        check("acc_pc2", {16'd0, pc_plus_2}, {16'd0, exp_pc + 16'd2});
        if (gap_chk && last_acc >= 0) check("gap", cyc - last_acc, 32'd2);
        last_acc = cyc;
        n_acc++;
        if (w[15:11] == 5'd0) exp_halt = 1'b1;
        exp_pc = exp_pc + 16'd2;
      end else if (instr_valid) begin
        pend_hold = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ex_redirect = 1'b0;
    ex_jr = 1'b0;
    ex_sum1 = '0;
    ex_sum2 = '0;
    id_ready = 1'b0;
    imem_done = 1'b0;
    imem_rdata = '0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", {16'd0, imem_addr}, 32'h0000);
    check("rst_instr", {16'd0, instr_out}, 32'h0800);
    check("rst_pc2", {16'd0, pc_plus_2}, 32'h0002);
    check("rst_vld", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    mem_busy = 1'b0;
    exp_pc = 16'h0000;
    exp_err = 1'b0;
    exp_halt = 1'b0;
    pend_hold = 1'b0;
    pend_redir = 1'b0;
    last_acc = -1;
    force_redir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (instr_valid) seen = 1'b1;
      else step();
    end
    if (!seen) check("wait_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic wait_accepts(input int n);
    int target_n = n_acc + n;
    for (int i = 0; i < 60 && n_acc < target_n; i++) step();
    check("accept_count", n_acc, target_n);
  endtask

  initial begin
    halt_addr = 16'h0001;
    lat_min = 1; lat_max = 1;
    rdy_pct = 100; redir_pct = 0; gap_chk = 1'b1;
    force_redir = 1'b0; force_jr = 1'b0; force_s1 = '0; force_s2 = '0;
    @(negedge clk);
    do_reset();

    // back-to-back fetch with single-cycle memory
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", {16'd0, imem_addr}, 32'h0000);
    wait_accepts(3);
    gap_chk = 1'b0;

    // decode stall with 3-cycle memory
    lat_min = 3; lat_max = 3; rdy_pct = 0;
    wait_valid();
    repeat (5) step();
    rdy_pct = 100;

    // redirect while an instruction waits in VALID
    rdy_pct = 0;
    wait_valid();
    force_redir = 1'b1; force_jr = 1'b0; force_s1 = 16'h0040; force_s2 = 16'h1234;
    step();
    rdy_pct = 100;
    wait_accepts(1);

    // redirect during an outstanding read forces a drain
    for (int i = 0; i < 10 && !(imem_req && !mem_busy); i++) step();
    force_redir = 1'b1; force_jr = 1'b1; force_s1 = 16'h5550; force_s2 = 16'h0100;
    step();
    check("drain_req", {31'd0, imem_req}, 32'd1);
    wait_accepts(2);

    // address wrap at the top of memory
    lat_min = 1; lat_max = 2;
    wait_valid();
    force_redir = 1'b1; force_jr = 1'b0; force_s1 = 16'hFFFE; force_s2 = 16'h0000;
    step();
    wait_accepts(2);

    // randomized traffic
    lat_min = 1; lat_max = 4; rdy_pct = 70; redir_pct = 10;
    repeat (3000) step();

    // halt instruction stops fetch; later redirects are ignored
    redir_pct = 0; rdy_pct = 100; halt_addr = 16'h0200;
    wait_valid();
    force_redir = 1'b1; force_jr = 1'b0; force_s1 = 16'h0200; force_s2 = 16'h0000;
    step();
    for (int i = 0; i < 20 && !exp_halt; i++) step();
    check("halt_reached", {31'd0, exp_halt}, 32'd1);
    redir_pct = 50;
    repeat (20) step();
    check("halt_sticky", {31'd0, halted}, 32'd1);

    // odd redirect target
    redir_pct = 0; halt_addr = 16'h0001; lat_min = 3; lat_max = 3;
    do_reset();
    step();
    force_redir = 1'b1; force_jr = 1'b0; force_s1 = 16'h0021; force_s2 = 16'h0000;
    step();
    check("odd_err", {31'd0, err}, 32'd1);
    check("odd_halt", {31'd0, halted}, 32'd1);
    repeat (3) step();

    // reset in the middle of a fetch, then resume normally
    do_reset();
    step();
    step();
    check("midfetch_req", {31'd0, imem_req}, 32'd1);
    do_reset();
    wait_accepts(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
